// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, LSB first, one bit per clock
//
// Computes diff = x - y - bin (mod 2^WIDTH) and the borrow out of the MSB.
// One result bit is produced per clock, so a subtraction takes WIDTH clocks.
// The result is reported with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width in bits, 1..32 (default 8)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  begin a subtraction; accepted only in IDLE or DONE
//   x, y   minuend / subtrahend, captured when start is accepted
//   bin    borrow in, captured when start is accepted
//   busy   high while the subtraction is running
//   done   one-cycle pulse when diff/bout hold the finished result
//   diff   result register; bits shift in from the MSB end while running
//   bout   borrow out of the MSB
//   ovf    signed overflow (present only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               bit_d;
    logic               br_nxt;
    logic [WIDTH-1:0]   diff_shift;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    // New bit enters at the MSB so that after WIDTH shifts the first
    // (least significant) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign diff_shift = bit_d;
        end else begin : g_shift_wn
            assign diff_shift = {bit_d, diff_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = x;
                    b_d     = y;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_nxt;
                diff_d = diff_shift;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // Borrow into the MSB is br_q at this edge; borrow out is br_nxt.
                    ovf_d   = br_q ^ br_nxt;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
